banked_data_memory_pipelined: RTL
=================================

Name: banked_data_memory_pipelined

Overview:
- Next-generation banked data memory for the out-of-order core's load/store units.
- NUM_PORTS requesters use valid/ready handshakes across NUM_BANKS word-interleaved single-port banks.
- Each bank arbitrates by oldest issue ID and supports byte-enable writes.
- Responses are tagged and return after a parametrised fixed latency, so ports can pipeline requests.

Parameters:
- MEM_DEPTH, 1024: total 32-bit words. Power of two, divisible by NUM_BANKS.
- NUM_PORTS, 2: requester ports.
- ID_WIDTH, 4: issue-ID width. Age compared modulo 2^ID_WIDTH.
- NUM_BANKS, 4: power of two, at least 1.
- READ_LATENCY, 1: cycles from accept to rsp_valid. Legal values 1 or 2 (2 adds an output register).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  [NUM_PORTS]  request present
- req_ready  out  [NUM_PORTS]  request accepted this cycle (combinational)
- req_id  in  [NUM_PORTS][ID_WIDTH]  issue ID
- req_addr  in  [NUM_PORTS][31:2]  word address
- req_wen  in  [NUM_PORTS]  1 = write
- req_be  in  [NUM_PORTS][3:0]  byte enables (writes only)
- req_wdata  in  [NUM_PORTS][31:0]  write data
- rsp_valid  out  [NUM_PORTS]  response valid
- rsp_id  out  [NUM_PORTS][ID_WIDTH]  echoed issue ID
- rsp_rdata  out  [NUM_PORTS][31:0]  read data; 0 for write acks
- bank_conflicts  out  [NUM_BANKS][31:0]  only with BANKED_MEM_STATS_EN

Behaviour:
- Index decode:
  - idx = req_addr[clog2(MEM_DEPTH)+1:2]; higher address bits are ignored (addresses wrap).
  - bank = idx[clog2(NUM_BANKS)-1:0]; local = remaining upper idx bits.
  - NUM_BANKS=1: bank = 0, local = idx.
- Arbitration (per bank, every cycle, combinational):
  - Among ports with req_valid targeting the bank, the oldest ID wins.
  - a is older than b iff signed (a - b) truncated to ID_WIDTH is negative.
  - Equal IDs: lowest port index wins.
  - req_ready[p] = 1 only for winners. At most one grant per bank per cycle; different banks are granted in parallel.
- Handshake:
  - A transfer occurs on req_valid & req_ready.
  - A requester holds valid and all fields stable until ready.
  - req_ready never depends on rsp state: there is no backpressure on responses.
- Write:
  - Bytes with req_be set are written at the accepting edge; be=0000 is a no-op write.
  - Ack: rsp_valid with rsp_rdata=0 after READ_LATENCY.
- Read:
  - Array read registered at the accepting edge.
  - rsp_valid/rsp_id/rsp_rdata presented READ_LATENCY cycles after accept, valid for exactly 1 cycle.
- Read-after-write to the same word in a later cycle returns the new data.
- Same-cycle same-bank contention: the loser keeps ready=0 and retries, with no data corruption.
- Back-to-back accepts on one port produce back-to-back responses in accept order.
- Response pipeline: a per-port shift register of {valid, id, is_write}, depth READ_LATENCY.
- Reset (rst_n=0 at a clk edge):
  - Memory is zeroed.
  - All pipeline valids are cleared; in-flight responses are dropped and never appear.
  - rsp_valid=0, rsp_id=0, rsp_rdata=0.
  - req_ready=0 while rst_n=0.
  - Counters are 0.
- Elaboration $fatal on an illegal NUM_BANKS, MEM_DEPTH, or READ_LATENCY.

Optional Feature:
- BANKED_MEM_STATS_EN defined:
  - bank_conflicts[b] increments by 1 each cycle in which 2 or more ports request bank b.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
- Undefined: bank_conflicts is absent from the port list and no counter logic exists.

Test Plan:
- Write then read, single port: write addr 0x10, be=1111, data 0xDEADBEEF, id 1. Next cycle read 0x10, id 2. Required: ack (rdata 0, id 1), then rsp_rdata=0xDEADBEEF with id 2, each READ_LATENCY after its accept.
- Byte enables: word holds 0x11223344; write be=0101, data 0xAABBCCDD. Read required = 0x11BB33DD.
- Bank conflict with ID wrap (ID_WIDTH=4): port0 id 14 and port1 id 1 read the same bank. Port0 is granted first (14 older than 1 modulo 16); port1 is granted the next cycle. Data correct; bank_conflicts[bank]=1 if enabled.
- Parallel banks: port0 reads word 0 (bank 0), port1 reads word 1 (bank 1) in the same cycle. Both ready=1 and both responses arrive in the same cycle.
- Address wrap (MEM_DEPTH=1024): write word index 1024+5, then read index 5. Required: the written data returns.
- Reset mid-flight (READ_LATENCY=2): assert rst_n=0 the cycle after a read is accepted. Required: no rsp_valid ever appears; a subsequent read of any address returns 0.

Source files
------------

// File: rtl/banked_data_memory_pipelined.sv
// Banked, word-interleaved data memory with oldest-ID arbitration and fixed-latency tagged responses.
// Define BANKED_MEM_STATS_EN to add the per-bank conflict counters on bank_conflicts.
module banked_data_memory_pipelined #(
    parameter int unsigned MEM_DEPTH    = 1024,
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS-1:0]                 req_valid,
    output logic [NUM_PORTS-1:0]                 req_ready,
    input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   req_id,
    input  logic [NUM_PORTS-1:0][31:2]           req_addr,
    input  logic [NUM_PORTS-1:0]                 req_wen,
    input  logic [NUM_PORTS-1:0][3:0]            req_be,
    input  logic [NUM_PORTS-1:0][31:0]           req_wdata,
    output logic [NUM_PORTS-1:0]                 rsp_valid,
    output logic [NUM_PORTS-1:0][ID_WIDTH-1:0]   rsp_id,
    output logic [NUM_PORTS-1:0][31:0]           rsp_rdata
`ifdef BANKED_MEM_STATS_EN
    ,
    output logic [NUM_BANKS-1:0][31:0]           bank_conflicts
`endif
);

    localparam int unsigned BANK_DEPTH = MEM_DEPTH / NUM_BANKS;
    localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned LOC_W      = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;

    if (NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
        $fatal(1, "NUM_BANKS must be a power of two and at least 1");
    end
    if (MEM_DEPTH < 1 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0 || (MEM_DEPTH % NUM_BANKS) != 0)
    begin : g_bad_depth
        $fatal(1, "MEM_DEPTH must be a power of two divisible by NUM_BANKS");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "READ_LATENCY must be 1 or 2");
    end

    logic [31:0]          mem      [NUM_BANKS][BANK_DEPTH];
    logic [BANK_W-1:0]    bank_sel [NUM_PORTS];
    logic [LOC_W-1:0]     loc_sel  [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] bank_gnt;
    logic [NUM_PORTS-1:0] accept;
    logic [NUM_BANKS-1:0] win_any;
    logic [ID_WIDTH-1:0]  win_id   [NUM_BANKS];

    logic                 pipe_v   [NUM_PORTS][READ_LATENCY];
    logic                 pipe_w   [NUM_PORTS][READ_LATENCY];
    logic [ID_WIDTH-1:0]  pipe_id  [NUM_PORTS][READ_LATENCY];
    logic [31:0]          pipe_d   [NUM_PORTS][READ_LATENCY];

    // Modulo-2^ID_WIDTH age: a is older when (a - b) wraps negative.
    function automatic logic older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    // Upper address bits fall away in the modulo, so addresses wrap.
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            bank_sel[p] = BANK_W'((32'(req_addr[p]) % MEM_DEPTH) % NUM_BANKS);
            loc_sel[p]  = LOC_W'((32'(req_addr[p]) % MEM_DEPTH) / NUM_BANKS);
        end
    end

    always_comb begin
        grant    = '0;
        bank_gnt = '0;
        win_any  = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            win_id[b] = '0;
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            bank_gnt = '0;
            // Ascending scan with strict "older" keeps the lowest port on ID ties.
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (req_valid[p] && 32'(bank_sel[p]) == b &&
                    (!win_any[b] || older(req_id[p], win_id[b]))) begin
                    win_any[b]  = 1'b1;
                    win_id[b]   = req_id[p];
                    bank_gnt    = '0;
                    bank_gnt[p] = 1'b1;
                end
            end
            grant = grant | bank_gnt;
        end
    end

    assign req_ready = rst_n ? grant : '0;
    assign accept    = req_valid & req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                for (int unsigned l = 0; l < BANK_DEPTH; l++) begin
                    mem[b][l] <= '0;
                end
            end
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                for (int unsigned s = 0; s < READ_LATENCY; s++) begin
                    pipe_v[p][s]  <= 1'b0;
                    pipe_w[p][s]  <= 1'b0;
                    pipe_id[p][s] <= '0;
                    pipe_d[p][s]  <= '0;
                end
            end
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (accept[p] && req_wen[p]) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        if (req_be[p][i]) begin
                            mem[bank_sel[p]][loc_sel[p]][8*i +: 8] <= req_wdata[p][8*i +: 8];
                        end
                    end
                end
                if (accept[p] && !req_wen[p]) begin
                    pipe_d[p][0] <= mem[bank_sel[p]][loc_sel[p]];
                end
                pipe_v[p][0]  <= accept[p];
                pipe_w[p][0]  <= req_wen[p];
                pipe_id[p][0] <= req_id[p];
                for (int unsigned s = 1; s < READ_LATENCY; s++) begin
                    pipe_v[p][s]  <= pipe_v[p][s-1];
                    pipe_w[p][s]  <= pipe_w[p][s-1];
                    pipe_id[p][s] <= pipe_id[p][s-1];
                    pipe_d[p][s]  <= pipe_d[p][s-1];
                end
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_id    = '0;
        rsp_rdata = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            rsp_valid[p] = pipe_v[p][READ_LATENCY-1];
            if (pipe_v[p][READ_LATENCY-1]) begin
                rsp_id[p] = pipe_id[p][READ_LATENCY-1];
                if (!pipe_w[p][READ_LATENCY-1]) begin
                    rsp_rdata[p] = pipe_d[p][READ_LATENCY-1];
                end
            end
        end
    end

`ifdef BANKED_MEM_STATS_EN
    logic [NUM_BANKS-1:0] contended;
    int unsigned          req_cnt;

    always_comb begin
        contended = '0;
        req_cnt   = 0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            req_cnt = 0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (req_valid[p] && 32'(bank_sel[p]) == b) begin
                    req_cnt = req_cnt + 1;
                end
            end
            contended[b] = (req_cnt >= 2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_conflicts <= '0;
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                if (contended[b] && bank_conflicts[b] != 32'hFFFF_FFFF) begin
                    bank_conflicts[b] <= bank_conflicts[b] + 32'd1;
                end
            end
        end
    end
`endif

endmodule
